fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port imem_req  output  1  fetch request valid.
REQ-005 SHALL have port imem_addr  output  32  fetch address, word-aligned.
REQ-006 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-007 SHALL have port imem_rvalid  input  1  read data valid.
REQ-008 SHALL have port imem_rdata  input  32  instruction word.
REQ-009 SHALL have port PCsrc  input  1  redirect (taken beq/bne, JAL) from execute.
REQ-010 SHALL have port PCTarget  input  32  redirect address (PC + ImmOp).
REQ-011 SHALL have port stall  input  1  decode cannot accept; hold IF/ID.
REQ-012 SHALL have port instr_valid  output  1  Instr/PC_D valid for decode.
REQ-013 SHALL have port Instr  output  32  instruction to decode and immediate extension.
REQ-014 SHALL have port PC_D  output  32  PC of Instr.
REQ-015 SHALL have port PCPlus4_D  output  32  PC_D + 4.

Function
REQ-016 SHALL use FSM states S_REQ, S_WAIT, S_HOLD, S_DROP.
REQ-017 S_REQ: imem_req=1, imem_addr=PC; on imem_gnt -> S_WAIT; imem_addr SHALL stay stable while imem_req && !imem_gnt.
REQ-018 At most one request outstanding; imem_req SHALL be 0 outside S_REQ.
REQ-019 S_WAIT, imem_rvalid && !stall: load IF/ID (Instr=imem_rdata, PC_D=PC, PCPlus4_D=PC+4, instr_valid=1), PC<=PC+4, -> S_REQ.
REQ-020 S_WAIT, imem_rvalid && stall: capture word in 1-entry skid buffer, -> S_HOLD; IF/ID unchanged.
REQ-021 S_HOLD: when stall=0, move skid into IF/ID, PC<=PC+4, -> S_REQ.
REQ-022 IF/ID SHALL hold all outputs unchanged while stall=1 and no redirect.
REQ-023 When stall=0 and no new word loads, instr_valid SHALL go 0 next cycle (bubble).
REQ-024 PCsrc=1 SHALL take priority over stall and responses: PC<={PCTarget[31:2],2'b00}, instr_valid<=0, skid cleared.
REQ-025 Redirect in S_REQ (with or without gnt): if gnt same cycle -> S_DROP, else stay S_REQ with new address next cycle.
REQ-026 Redirect in S_WAIT without rvalid -> S_DROP; with rvalid same cycle -> response discarded, -> S_REQ.
REQ-027 S_DROP: discard next imem_rvalid data, then -> S_REQ; PCsrc here only updates PC.
REQ-028 Redirect in S_HOLD: discard skid, -> S_REQ.
REQ-029 PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0.
REQ-030 First valid instruction to decode SHALL appear no earlier than 2 cycles after rst_n deasserts with zero-wait memory (req+gnt, rvalid).

Reset
REQ-031 On rst_n=0 at a rising edge: PC=RESET_PC, state=S_REQ, instr_valid=0, Instr=32'h0000_0013 (NOP), PC_D=0, PCPlus4_D=0, skid empty.
REQ-032 imem_req SHALL be 0 during reset; reset mid-transaction SHALL abandon it, and the first rvalid after reset without a post-reset grant SHALL be ignored.

Structure
REQ-033 cpu_pkg SHALL hold RESET_PC default, NOP encoding 32'h0000_0013, and the fetch_state_t enum.
REQ-034 IF/ID register with stall/flush SHALL be sub-module if_id_reg; FSM, PC and skid stay in fetch_unit.

Verification
REQ-035 Zero-wait memory, no stall, 4 fetches -> PC_D sequence 0,4,8,C, Instr matches memory, PCPlus4_D = PC_D+4.
REQ-036 stall=1 for 3 cycles as word at 8 returns -> IF/ID holds PC_D=4; after release PC_D=8 once, no loss or duplicate.
REQ-037 PCsrc=1, PCTarget=32'h0000_0103 while in S_WAIT -> pending response dropped, next imem_addr=32'h0000_0100, instr_valid=0 for one cycle.
REQ-038 PCsrc and stall both 1 -> redirect wins, instr_valid=0 next cycle, skid empty.
REQ-039 PC=32'hFFFF_FFFC fetched -> next imem_addr=32'h0000_0000.
REQ-040 rst_n=0 during S_WAIT, stale rvalid after release -> ignored; first fetch addr=RESET_PC, outputs at reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
// Contents:
//   RESET_PC_DEFAULT - default address of the first fetch after reset
//   NOP_INSTR        - canonical NOP (addi x0, x0, 0) held in IF/ID after reset
//   fetch_state_t    - fetch FSM state encoding
//   word_align()     - clears the byte-offset bits of an address
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // request presented to instruction memory
        S_WAIT = 2'd1,   // request granted, waiting for read data
        S_HOLD = 2'd2,   // word parked in skid buffer while decode stalls
        S_DROP = 2'd3    // redirected with a response in flight; discard it
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall and flush.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   flush               - redirect: invalidate the entry (highest priority)
//   load                - capture a new instruction word
//   stall               - decode cannot accept: hold everything
//   instr_in/pc_in/pc_plus4_in - data captured on load
//   valid/instr/pc/pc_plus4    - registered outputs toward decode
// With neither load nor stall the entry becomes a bubble (valid drops).
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load,
    input  logic        stall,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc_plus4_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic        valid_r;
    logic [31:0] instr_r;
    logic [31:0] pc_r;
    logic [31:0] pc_plus4_r;

    // IF/ID storage: flush beats load, load beats stall, otherwise bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r    <= 1'b0;
            instr_r    <= NOP_INSTR;
            pc_r       <= 32'h0000_0000;
            pc_plus4_r <= 32'h0000_0000;
        end else if (flush) begin
            valid_r    <= 1'b0;
        end else if (load) begin
            valid_r    <= 1'b1;
            instr_r    <= instr_in;
            pc_r       <= pc_in;
            pc_plus4_r <= pc_plus4_in;
        end else if (!stall) begin
            valid_r    <= 1'b0;
        end else begin
            valid_r    <= valid_r;
        end
    end

    assign valid    = valid_r;
    assign instr    = instr_r;
    assign pc       = pc_r;
    assign pc_plus4 = pc_plus4_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, fetch FSM, one-entry skid buffer, IF/ID register.
// Ports:
//   clk, rst_n                     - clock, synchronous active-low reset
//   imem_req/imem_addr (out)       - fetch request and word-aligned address
//   imem_gnt/imem_rvalid/imem_rdata- memory handshake and returned word
//   PCsrc/PCTarget                 - redirect from execute (priority over all)
//   stall                          - decode cannot accept; hold IF/ID
//   instr_valid/Instr/PC_D/PCPlus4_D - IF/ID contents toward decode
// Only one request is ever outstanding, so PC always names the word being
// fetched and only advances once that word has been handed to IF/ID.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        PCsrc,
    input  logic [31:0] PCTarget,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] Instr,
    output logic [31:0] PC_D,
    output logic [31:0] PCPlus4_D
);

    fetch_state_t state_r;
    fetch_state_t state_nx_s;
    logic [31:0]  pc_r;
    logic [31:0]  skid_r;
    logic [31:0]  pc_plus4_s;

    logic         imem_req_s;
    logic         ifid_load_s;
    logic [31:0]  ifid_instr_s;
    logic         pc_adv_s;
    logic         skid_cap_s;

    assign pc_plus4_s = pc_r + 32'd4;   // wraps modulo 2^32

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_REQ;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; a redirect always overrides normal flow
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_REQ: begin
                // Redirect with a same-cycle grant leaves a response in flight
                if (PCsrc) begin
                    state_nx_s = imem_gnt ? S_DROP : S_REQ;
                end else if (imem_gnt) begin
                    state_nx_s = S_WAIT;
                end else begin
                    state_nx_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (PCsrc) begin
                    state_nx_s = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    state_nx_s = stall ? S_HOLD : S_REQ;
                end else begin
                    state_nx_s = S_WAIT;
                end
            end
            S_HOLD: begin
                if (PCsrc || !stall) begin
                    state_nx_s = S_REQ;
                end else begin
                    state_nx_s = S_HOLD;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_nx_s = S_REQ;
                end else begin
                    state_nx_s = S_DROP;
                end
            end
            default: begin
                state_nx_s = S_REQ;
            end
        endcase
    end

    // FSM outputs: memory request plus IF/ID, PC and skid controls
    always_comb begin
        imem_req_s   = 1'b0;
        ifid_load_s  = 1'b0;
        ifid_instr_s = imem_rdata;
        pc_adv_s     = 1'b0;
        skid_cap_s   = 1'b0;
        case (state_r)
            S_REQ: begin
                // Gated by rst_n so no request is visible while reset is held
                imem_req_s = rst_n;
            end
            S_WAIT: begin
                if (!PCsrc && imem_rvalid) begin
                    if (!stall) begin
                        ifid_load_s = 1'b1;
                        pc_adv_s    = 1'b1;
                    end else begin
                        skid_cap_s  = 1'b1;
                    end
                end else begin
                    ifid_load_s = 1'b0;
                end
            end
            S_HOLD: begin
                if (!PCsrc && !stall) begin
                    ifid_load_s  = 1'b1;
                    ifid_instr_s = skid_r;
                    pc_adv_s     = 1'b1;
                end else begin
                    ifid_load_s  = 1'b0;
                end
            end
            S_DROP: begin
                imem_req_s = 1'b0;
            end
            default: begin
                imem_req_s = 1'b0;
            end
        endcase
    end

    // PC and skid buffer; the skid is only meaningful in S_HOLD, so leaving
    // S_HOLD (release or redirect) empties it without a separate flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r   <= word_align(RESET_PC);
            skid_r <= NOP_INSTR;
        end else if (PCsrc) begin
            pc_r   <= word_align(PCTarget);
            skid_r <= NOP_INSTR;
        end else begin
            if (pc_adv_s) begin
                pc_r <= pc_plus4_s;
            end
            if (skid_cap_s) begin
                skid_r <= imem_rdata;
            end
        end
    end

    assign imem_req  = imem_req_s;
    assign imem_addr = pc_r;

    if_id_reg u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (PCsrc),
        .load       (ifid_load_s),
        .stall      (stall),
        .instr_in   (ifid_instr_s),
        .pc_in      (pc_r),
        .pc_plus4_in(pc_plus4_s),
        .valid      (instr_valid),
        .instr      (Instr),
        .pc         (PC_D),
        .pc_plus4   (PCPlus4_D)
    );

endmodule
